// File: rtl/eth_fcs_append.sv
// eth_fcs_append
// Transmit framing stage wrapped around an external byte-wide CRC-32 engine.
// Forwards an Ethernet frame (DA..payload, no FCS), optionally zero-pads it to
// MIN_LEN bytes, feeds every frame/pad byte to the CRC engine and, once the
// engine result has settled, appends the 4-byte FCS (LSB first) with m_last on
// the final FCS byte.
//
// Build option:
//   ETH_FCS_PAD_EN  defined   -> short frames are zero-padded to MIN_LEN bytes.
//                   undefined -> no padding; output length = input length + 4.
//
// Parameters:
//   MIN_LEN      padding target in bytes (before FCS)
//   CRC_LATENCY  cycles from the last crc_en cycle until crc_value is valid (1..7)
//   CNT_W        byte counter width; the counter saturates
//
// Ports:
//   clk, rst     clock, synchronous active-high reset
//   s_data/s_valid/s_last/s_ready   input byte stream
//   m_data/m_valid/m_last/m_ready   output byte stream (frame, pad, FCS)
//   crc_data/crc_en/crc_clr         drive the CRC engine (data_in / enable / clr)
//   crc_value                       CRC engine result (crc_out)
module eth_fcs_append #(
  parameter int unsigned MIN_LEN     = 60,
  parameter int unsigned CRC_LATENCY = 1,
  parameter int unsigned CNT_W       = 11
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  s_data,
  input  logic        s_valid,
  input  logic        s_last,
  output logic        s_ready,
  output logic [7:0]  m_data,
  output logic        m_valid,
  output logic        m_last,
  input  logic        m_ready,
  output logic [7:0]  crc_data,
  output logic        crc_en,
  output logic        crc_clr,
  input  logic [31:0] crc_value
);

  // Elaboration-time sanity checks on the configuration.
  if (CRC_LATENCY < 1 || CRC_LATENCY > 7) begin : g_bad_latency
    $error("eth_fcs_append: CRC_LATENCY must be in 1..7");
  end
  if (MIN_LEN >= (1 << CNT_W)) begin : g_bad_cnt_w
    $error("eth_fcs_append: CNT_W too narrow to count MIN_LEN bytes");
  end

`ifdef ETH_FCS_PAD_EN
  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_DATA     = 3'd1,
    S_PAD      = 3'd2,
    S_WAIT_CRC = 3'd3,
    S_FCS      = 3'd4
  } state_t;
`else
  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_DATA     = 3'd1,
    S_WAIT_CRC = 3'd3,
    S_FCS      = 3'd4
  } state_t;
`endif

  state_t           state_q;
  state_t           state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_inc;
  logic [2:0]       lat_cnt;
  logic             lat_done;
  logic [31:0]      fcs_q;
  logic [1:0]       fcs_idx;

  logic             permit;
  logic             load_crc;   // frame or pad byte loaded (also goes to CRC)
  logic             load_fcs;   // FCS byte loaded
  logic             load;
  logic [7:0]       load_byte;
  logic             load_last;

  // The output register may take a new byte when empty or being drained.
  assign permit  = !m_valid || m_ready;
  assign load    = load_crc || load_fcs;
  assign cnt_inc = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);

  // lat_cnt restarts on the edge that set the final crc_en (the WAIT_CRC entry
  // edge), so lat_cnt == CRC_LATENCY marks CRC_LATENCY+1 edges since then.
  assign lat_done = (state_q == S_WAIT_CRC) && (lat_cnt == 3'(CRC_LATENCY));

`ifdef ETH_FCS_PAD_EN
  logic [CNT_W:0] cnt_plus1;
  logic [CNT_W:0] min_len_c;
  assign cnt_plus1 = {1'b0, cnt_q} + (CNT_W+1)'(1);
  assign min_len_c = (CNT_W+1)'(MIN_LEN);
`endif

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; every data-driven transition is qualified by an actual load
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (s_valid) state_d = S_DATA;
      end
      S_DATA: begin
        if (load_crc && s_last) begin
`ifdef ETH_FCS_PAD_EN
          state_d = (cnt_plus1 < min_len_c) ? S_PAD : S_WAIT_CRC;
`else
          state_d = S_WAIT_CRC;
`endif
        end
      end
`ifdef ETH_FCS_PAD_EN
      S_PAD: begin
        if (load_crc && (cnt_plus1 >= min_len_c)) state_d = S_WAIT_CRC;
      end
`endif
      S_WAIT_CRC: begin
        if (lat_done) state_d = S_FCS;
      end
      S_FCS: begin
        if (load_fcs && (fcs_idx == 2'd3)) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Output / load decode
  always_comb begin
    s_ready   = 1'b0;
    crc_clr   = 1'b0;
    load_crc  = 1'b0;
    load_fcs  = 1'b0;
    load_byte = 8'h00;
    load_last = 1'b0;
    case (state_q)
      S_IDLE: begin
        crc_clr = 1'b1;
      end
      S_DATA: begin
        s_ready = permit;
        if (s_valid && permit) begin
          load_crc  = 1'b1;
          load_byte = s_data;
        end
      end
`ifdef ETH_FCS_PAD_EN
      S_PAD: begin
        load_crc = permit;
      end
`endif
      S_FCS: begin
        if (permit) begin
          load_fcs  = 1'b1;
          load_byte = fcs_q[{fcs_idx, 3'b000} +: 8];
          load_last = (fcs_idx == 2'd3);
        end
      end
      default: ;
    endcase
  end

  // Output register, CRC feed and counters
  always_ff @(posedge clk) begin
    if (rst) begin
      m_valid  <= 1'b0;
      m_last   <= 1'b0;
      m_data   <= 8'h00;
      crc_en   <= 1'b0;
      crc_data <= 8'h00;
      cnt_q    <= '0;
      lat_cnt  <= '0;
      fcs_idx  <= '0;
    end else begin
      crc_en <= load_crc;
      if (load_crc) crc_data <= load_byte;

      if (load) begin
        m_valid <= 1'b1;
        m_data  <= load_byte;
        m_last  <= load_last;
      end else if (m_ready) begin
        m_valid <= 1'b0;
        m_last  <= 1'b0;
      end

      if (state_q == S_IDLE)  cnt_q <= '0;
      else if (load_crc)      cnt_q <= cnt_inc;

      lat_cnt <= (state_q == S_WAIT_CRC) ? lat_cnt + 3'd1 : 3'd0;

      if (state_q != S_FCS)   fcs_idx <= 2'd0;
      else if (load_fcs)      fcs_idx <= fcs_idx + 2'd1;
    end
  end

  // FCS capture once the engine output has settled
  always_ff @(posedge clk) begin
    if (lat_done) fcs_q <= crc_value;
  end

endmodule

// File: tb/tb_eth_fcs_append.sv
module tb_eth_fcs_append;

  localparam int MIN_LEN = 60;

  logic        clk;
  logic        rst;
  logic        s_valid;
  logic        s_last;
  logic [7:0]  s_data;
  logic        m_ready;
  int          sel;
  int          rmode;

  logic [1:0]       s_valid_w, m_ready_w, s_ready_w, m_valid_w, m_last_w;
  logic [1:0]       crc_en_w, crc_clr_w;
  logic [1:0][7:0]  m_data_w, crc_data_w;
  logic [1:0][31:0] crc_value_w;

  assign s_valid_w[0] = s_valid && (sel == 0);
  assign s_valid_w[1] = s_valid && (sel == 1);
  assign m_ready_w[0] = (sel == 0) ? m_ready : 1'b1;
  assign m_ready_w[1] = (sel == 1) ? m_ready : 1'b1;

  eth_fcs_append #(.MIN_LEN(MIN_LEN), .CRC_LATENCY(1), .CNT_W(11)) dut0 (
    .clk(clk), .rst(rst),
    .s_data(s_data), .s_valid(s_valid_w[0]), .s_last(s_last), .s_ready(s_ready_w[0]),
    .m_data(m_data_w[0]), .m_valid(m_valid_w[0]), .m_last(m_last_w[0]), .m_ready(m_ready_w[0]),
    .crc_data(crc_data_w[0]), .crc_en(crc_en_w[0]), .crc_clr(crc_clr_w[0]),
    .crc_value(crc_value_w[0])
  );

  eth_fcs_append #(.MIN_LEN(MIN_LEN), .CRC_LATENCY(3), .CNT_W(11)) dut1 (
    .clk(clk), .rst(rst),
    .s_data(s_data), .s_valid(s_valid_w[1]), .s_last(s_last), .s_ready(s_ready_w[1]),
    .m_data(m_data_w[1]), .m_valid(m_valid_w[1]), .m_last(m_last_w[1]), .m_ready(m_ready_w[1]),
    .crc_data(crc_data_w[1]), .crc_en(crc_en_w[1]), .crc_clr(crc_clr_w[1]),
    .crc_value(crc_value_w[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Byte-serial reflected CRC-32 step used by the stand-in CRC engines.
  function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c;
    for (int b = 0; b < 8; b++) r = (r[0] ^ d[b]) ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
    return r;
  endfunction

  // CRC engines: latency 1 for dut0, 3 for dut1 (extra output registers).
  for (genvar g = 0; g < 2; g++) begin : g_eng
    localparam int L = (g == 0) ? 1 : 3;
    logic [31:0] st;
    logic [31:0] pipe [7];
    always @(posedge clk) begin
      if (crc_clr_w[g])     st <= 32'hFFFFFFFF;
      else if (crc_en_w[g]) st <= crc_byte(st, crc_data_w[g]);
      pipe[0] <= ~st;
      for (int i = 1; i < 7; i++) pipe[i] <= pipe[i-1];
    end
    if (L == 1) begin : g_l1
      assign crc_value_w[g] = ~st;
    end else begin : g_ln
      assign crc_value_w[g] = pipe[L-2];
    end
  end

  // Reference FCS: MSB-first shift register over the LSB-first bit stream,
  // then reflected and complemented (standard Ethernet FCS).
  function automatic logic [31:0] crc32_ref(input byte unsigned d[$]);
    logic [31:0] c, r;
    logic        fb;
    c = 32'hFFFFFFFF;
    foreach (d[i]) begin
      for (int b = 0; b < 8; b++) begin
        fb = c[31] ^ d[i][b];
        c  = c << 1;
        if (fb) c = c ^ 32'h04C11DB7;
      end
    end
    for (int i = 0; i < 32; i++) r[i] = c[31-i];
    return ~r;
  endfunction

  // Frame model: padded byte stream seen by the CRC engine and full output.
  function automatic void model(input byte unsigned f[$], output byte unsigned pb[$],
                                output byte unsigned ob[$]);
    logic [31:0] fcs;
    pb = f;
`ifdef ETH_FCS_PAD_EN
    while (pb.size() < MIN_LEN) pb.push_back(8'h00);
`endif
    fcs = crc32_ref(pb);
    ob = pb;
    for (int k = 0; k < 4; k++) ob.push_back(fcs[8*k +: 8]);
  endfunction

  function automatic int exp_crc_len(input int len);
`ifdef ETH_FCS_PAD_EN
    return (len < MIN_LEN) ? MIN_LEN : len;
`else
    return len;
`endif
  endfunction

  function automatic int exp_out_len(input int len);
    return exp_crc_len(len) + 4;
  endfunction

  // Scoreboard state
  int n_chk, n_fail;
  byte unsigned out_q[$];
  bit           last_q[$];
  byte unsigned crc_q[$];
  int  n_last, cyc, last_crc_cyc, first_fcs_cyc, fcs_pos, crc_mark, clr_mid;

  task automatic chk(input string name, input longint act, input longint exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic clear_mon();
    out_q.delete(); last_q.delete(); crc_q.delete();
    n_last = 0; first_fcs_cyc = -1; last_crc_cyc = -1; fcs_pos = -1;
    crc_mark = -1; clr_mid = 0;
  endtask

  // Monitor: samples on the falling edge what transfers at the next rising edge.
  initial begin
    bit          prev_stall;
    logic [7:0]  prev_d;
    logic        prev_l;
    logic        mv, ml;
    logic [7:0]  md;
    prev_stall = 0; prev_d = 0; prev_l = 0; cyc = 0;
    forever begin
      @(negedge clk);
      cyc++;
      if (rst) begin
        prev_stall = 0;
      end else begin
        mv = m_valid_w[sel]; md = m_data_w[sel]; ml = m_last_w[sel];
        if (prev_stall) begin
          n_chk++;
          if (!(mv && md == prev_d && ml == prev_l)) begin
            n_fail++;
            $display("FAIL hold_stable: got v=%0b d=%02h l=%0b expected v=1 d=%02h l=%0b",
                     mv, md, ml, prev_d, prev_l);
          end
        end
        prev_stall = mv && !m_ready;
        prev_d = md; prev_l = ml;
        if (mv && m_ready) begin
          if (out_q.size() == fcs_pos && first_fcs_cyc < 0) first_fcs_cyc = cyc;
          out_q.push_back(md);
          last_q.push_back(ml);
          if (ml) n_last++;
        end
        if (crc_en_w[sel]) begin
          crc_q.push_back(crc_data_w[sel]);
          last_crc_cyc = cyc;
        end
        if (crc_clr_w[sel] && n_last == 1 && crc_q.size() == crc_mark) clr_mid++;
      end
    end
  end

  // m_ready driver: 0 = always ready, 1 = toggle each cycle, 2 = random.
  initial begin
    m_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      case (rmode)
        0:       m_ready = 1'b1;
        1:       m_ready = !m_ready;
        default: m_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got no end of test expected finish");
    $fatal(1, "simulation timeout");
  end

  task automatic send_frame(input byte unsigned f[$], input bit gaps, input int abort_at,
                            output bit ok);
    ok = 1;
    for (int i = 0; i < f.size(); i++) begin
      if (gaps && $urandom_range(0, 2) == 0) begin
        s_valid = 0;
        repeat ($urandom_range(1, 2)) @(posedge clk);
        #1;
      end
      s_valid = 1; s_data = f[i]; s_last = (i == f.size() - 1);
      if (i == abort_at) begin
        rst = 1;
        @(posedge clk); #1;
        rst = 0; s_valid = 0; s_last = 0;
        return;
      end
      begin
        int t;
        bit got;
        t = 0; got = 0;
        while (!got && t < 2000) begin
          @(negedge clk);
          got = s_ready_w[sel];
          @(posedge clk); #1;
          t++;
        end
        if (!got) begin
          ok = 0;
          return;
        end
      end
    end
  endtask

  task automatic wait_last(input int n, output bit ok);
    int t;
    t = 0;
    while (n_last < n && t < 3000) begin
      @(negedge clk);
      t++;
    end
    ok = (n_last >= n);
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic check_frames(input string name, input byte unsigned eb[$], input bit el[$],
                              input byte unsigned ec[$]);
    int mis;
    chk({name, "_out_len"}, out_q.size(), eb.size());
    mis = -1;
    foreach (eb[i]) if (mis < 0 && (i >= out_q.size() || out_q[i] != eb[i])) mis = i;
    n_chk++;
    if (mis >= 0) begin
      n_fail++;
      $display("FAIL %s_bytes: idx %0d got %02h expected %02h", name, mis,
               (mis < out_q.size()) ? out_q[mis] : 8'hxx, eb[mis]);
    end
    mis = -1;
    foreach (el[i]) if (mis < 0 && (i >= last_q.size() || last_q[i] != el[i])) mis = i;
    n_chk++;
    if (mis >= 0) begin
      n_fail++;
      $display("FAIL %s_m_last: idx %0d got %0b expected %0b", name, mis,
               (mis < last_q.size()) ? last_q[mis] : 1'b0, el[mis]);
    end
    chk({name, "_crc_en_count"}, crc_q.size(), ec.size());
    mis = -1;
    foreach (ec[i]) if (mis < 0 && (i >= crc_q.size() || crc_q[i] != ec[i])) mis = i;
    n_chk++;
    if (mis >= 0) begin
      n_fail++;
      $display("FAIL %s_crc_data: idx %0d got %02h expected %02h", name, mis,
               (mis < crc_q.size()) ? crc_q[mis] : 8'hxx, ec[mis]);
    end
  endtask

  typedef struct {
    int len;      // input length
    int kind;     // 0 = ARP 60 (zero-filled), 1 = ARP 42, 2 = random bytes
    int rmode;    // m_ready pattern
    bit gaps;     // random s_valid gaps
    int sel;      // 0 = CRC_LATENCY 1, 1 = CRC_LATENCY 3
    int exp_len;  // expected output bytes
    int exp_crc;  // expected crc_en pulses
  } vec_t;

  localparam int NV = 10;
  vec_t vecs [NV];
  byte unsigned arp_hdr [42];

  function automatic void build(input int kind, input int len, output byte unsigned f[$]);
    f.delete();
    if (kind == 2) begin
      for (int i = 0; i < len; i++) f.push_back(8'($urandom_range(0, 255)));
    end else begin
      foreach (arp_hdr[i]) f.push_back(arp_hdr[i]);
      if (kind == 0) while (f.size() < 60) f.push_back(8'h00);
    end
  endfunction

  initial begin
    byte unsigned f[$], pb[$], ob[$], fa[$], pa[$], oa[$];
    bit           el[$];
    bit           ok;
    int           lat;

    n_chk = 0; n_fail = 0;
    arp_hdr = '{8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'hAA, 8'hBB, 8'hCC, 8'hDD,
                8'hEE, 8'hFF, 8'h08, 8'h06, 8'h00, 8'h01, 8'h08, 8'h00, 8'h06, 8'h04,
                8'h00, 8'h02, 8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE, 8'hFF, 8'hC0, 8'hA8,
                8'h01, 8'h01, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'hC0, 8'hA8,
                8'h01, 8'h64};

    vecs[0] = '{len:60,  kind:0, rmode:0, gaps:0, sel:0, exp_len:exp_out_len(60),  exp_crc:exp_crc_len(60)};
    vecs[1] = '{len:42,  kind:1, rmode:0, gaps:0, sel:0, exp_len:exp_out_len(42),  exp_crc:exp_crc_len(42)};
    vecs[2] = '{len:60,  kind:0, rmode:1, gaps:1, sel:0, exp_len:exp_out_len(60),  exp_crc:exp_crc_len(60)};
    vecs[3] = '{len:1,   kind:2, rmode:0, gaps:0, sel:0, exp_len:exp_out_len(1),   exp_crc:exp_crc_len(1)};
    vecs[4] = '{len:59,  kind:2, rmode:0, gaps:0, sel:0, exp_len:exp_out_len(59),  exp_crc:exp_crc_len(59)};
    vecs[5] = '{len:61,  kind:2, rmode:1, gaps:0, sel:0, exp_len:exp_out_len(61),  exp_crc:exp_crc_len(61)};
    vecs[6] = '{len:100, kind:2, rmode:2, gaps:1, sel:0, exp_len:exp_out_len(100), exp_crc:exp_crc_len(100)};
    vecs[7] = '{len:60,  kind:0, rmode:0, gaps:0, sel:1, exp_len:exp_out_len(60),  exp_crc:exp_crc_len(60)};
    vecs[8] = '{len:20,  kind:2, rmode:1, gaps:1, sel:1, exp_len:exp_out_len(20),  exp_crc:exp_crc_len(20)};
    vecs[9] = '{len:42,  kind:1, rmode:0, gaps:0, sel:1, exp_len:exp_out_len(42),  exp_crc:exp_crc_len(42)};

    sel = 0; rmode = 0;
    rst = 1; s_valid = 0; s_last = 0; s_data = 8'h00;
    clear_mon();
    repeat (3) @(posedge clk);
    #1;
    s_valid = 1;
    @(negedge clk);
    chk("rst_m_valid",  m_valid_w[0],  0);
    chk("rst_m_last",   m_last_w[0],   0);
    chk("rst_m_data",   m_data_w[0],   0);
    chk("rst_crc_en",   crc_en_w[0],   0);
    chk("rst_crc_data", crc_data_w[0], 0);
    chk("rst_crc_clr",  crc_clr_w[0],  1);
    chk("rst_s_ready",  s_ready_w[0],  0);
    chk("rst_crc_clr_l3", crc_clr_w[1], 1);
    @(posedge clk); #1;
    s_valid = 0; rst = 0;
    repeat (2) @(posedge clk);
    #1;

    for (int r = 0; r < NV; r++) begin
      sel = vecs[r].sel; rmode = vecs[r].rmode;
      build(vecs[r].kind, vecs[r].len, f);
      model(f, pb, ob);
      clear_mon();
      fcs_pos = pb.size();
      send_frame(f, vecs[r].gaps, -1, ok);
      s_valid = 0; s_last = 0;
      chk($sformatf("v%0d_input_accepted", r), ok, 1);
      wait_last(1, ok);
      chk($sformatf("v%0d_frame_end", r), ok, 1);
      chk($sformatf("v%0d_table_len", r), out_q.size(), vecs[r].exp_len);
      chk($sformatf("v%0d_table_crc_en", r), crc_q.size(), vecs[r].exp_crc);
      el.delete();
      foreach (ob[i]) el.push_back(i == ob.size() - 1);
      check_frames($sformatf("v%0d", r), ob, el, pb);
      if (vecs[r].rmode == 0) begin
        lat = (vecs[r].sel == 0) ? 1 : 3;
        chk($sformatf("v%0d_fcs_latency", r), first_fcs_cyc - last_crc_cyc, lat + 2);
      end
      rmode = 0;
      repeat (3) @(posedge clk);
      #1;
    end

    // Reset during the 30th data byte, then a clean frame.
    sel = 0; rmode = 0;
    build(2, 50, f);
    clear_mon();
    send_frame(f, 0, 29, ok);
    @(negedge clk);
    chk("abort_m_valid", m_valid_w[0], 0);
    chk("abort_crc_en",  crc_en_w[0],  0);
    chk("abort_crc_clr", crc_clr_w[0], 1);
    @(posedge clk); #1;
    build(1, 42, f);
    model(f, pb, ob);
    clear_mon();
    fcs_pos = pb.size();
    send_frame(f, 0, -1, ok);
    s_valid = 0; s_last = 0;
    chk("after_abort_accepted", ok, 1);
    wait_last(1, ok);
    chk("after_abort_end", ok, 1);
    el.delete();
    foreach (ob[i]) el.push_back(i == ob.size() - 1);
    check_frames("after_abort", ob, el, pb);

    // Back-to-back frames with s_valid held high.
    build(2, 45, fa);
    model(fa, pa, oa);
    build(2, 70, f);
    model(f, pb, ob);
    clear_mon();
    crc_mark = pa.size();
    send_frame(fa, 0, -1, ok);
    chk("b2b_a_accepted", ok, 1);
    send_frame(f, 0, -1, ok);
    chk("b2b_b_accepted", ok, 1);
    s_valid = 0; s_last = 0;
    wait_last(2, ok);
    chk("b2b_end", ok, 1);
    el.delete();
    foreach (oa[i]) el.push_back(i == oa.size() - 1);
    foreach (ob[i]) el.push_back(i == ob.size() - 1);
    check_frames("b2b", {oa, ob}, el, {pa, pb});
    n_chk++;
    if (clr_mid < 1) begin
      n_fail++;
      $display("FAIL b2b_crc_clr_gap: got %0d cycles expected at least 1", clr_mid);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
